// File: rtl/tt_selftest_harness.sv
// On-chip BIST harness for a Tiny Tapeout user core: LFSR stimulus, MISR response compaction, golden compare.
// Optional macro HARNESS_UIO_CAPTURE_EN folds enabled uio outputs into the upper MISR byte lane.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | one cycle: reseed LFSR, clear MISR, counters, stimulus and pass
// RUN   | NPAT patterns driven, one LFSR step and one MISR step per cycle
// FLUSH | stimulus held, LATENCY+1 MISR steps drain the core pipeline
// DONE  | signature final, pass valid, waits for next start
module tt_selftest_harness #(
    parameter int                 DATA_W    = 8,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_POLY = 16'hB400,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1,
    parameter int                 MISR_W    = 16,
    parameter logic [MISR_W-1:0]  MISR_POLY = 16'h8005,
    parameter int                 NPAT      = 256,
    parameter int                 LATENCY   = 1,
    parameter logic [MISR_W-1:0]  GOLDEN    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    output logic [DATA_W-1:0] dut_ui,
    output logic [DATA_W-1:0] dut_uio_in,
    input  logic [DATA_W-1:0] dut_uo,
    input  logic [DATA_W-1:0] dut_uio_out,
    input  logic [DATA_W-1:0] dut_uio_oe,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int CNT_W = $clog2(NPAT + 1);

    generate
        if (LFSR_W < 2 * DATA_W) begin : g_chk_lfsr
            $error("LFSR_W must be at least 2*DATA_W");
        end
        if (MISR_W < DATA_W) begin : g_chk_misr
            $error("MISR_W must be at least DATA_W");
        end
        if (LATENCY < 0 || LATENCY > 7) begin : g_chk_lat
            $error("LATENCY must be in 0..7");
        end
        if (NPAT < 1) begin : g_chk_npat
            $error("NPAT must be at least 1");
        end
`ifdef HARNESS_UIO_CAPTURE_EN
        if (MISR_W < 2 * DATA_W) begin : g_chk_uio
            $error("HARNESS_UIO_CAPTURE_EN needs MISR_W >= 2*DATA_W");
        end
`endif
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [LFSR_W-1:0]  lfsr, lfsr_step;
    logic [MISR_W-1:0]  misr, misr_step, capture;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         fcnt;
    logic               pass_q;
    logic [DATA_W-1:0]  ui_q, uio_q;
    logic               last_pat, last_flush;

    assign last_pat   = (cnt == CNT_W'(NPAT - 1));
    assign last_flush = (fcnt == 3'(LATENCY));

    always_comb begin
        lfsr_step = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_step = (lfsr >> 1) ^ LFSR_POLY;
        end
    end

    always_comb begin
        capture = '0;
        capture[DATA_W-1:0] = dut_uo;
`ifdef HARNESS_UIO_CAPTURE_EN
        capture[2*DATA_W-1:DATA_W] = dut_uio_out & dut_uio_oe;
`endif
    end

`ifndef HARNESS_UIO_CAPTURE_EN
    logic unused_uio;
    assign unused_uio = ^{dut_uio_out, dut_uio_oe};
`endif

    always_comb begin
        misr_step = {misr[MISR_W-2:0], 1'b0} ^ capture;
        if (misr[MISR_W-1]) begin
            misr_step = {misr[MISR_W-2:0], 1'b0} ^ MISR_POLY ^ capture;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN:   if (last_pat) state_nxt = S_FLUSH;
            S_FLUSH: if (last_flush) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Stimulus is cleared in LOAD so the first RUN capture is identical for every run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr   <= LFSR_SEED;
            misr   <= '0;
            cnt    <= '0;
            fcnt   <= '0;
            pass_q <= 1'b0;
            ui_q   <= '0;
            uio_q  <= '0;
        end else if (ena) begin
            case (state)
                S_LOAD: begin
                    lfsr   <= LFSR_SEED;
                    misr   <= '0;
                    cnt    <= '0;
                    fcnt   <= '0;
                    pass_q <= 1'b0;
                    ui_q   <= '0;
                    uio_q  <= '0;
                end
                S_RUN: begin
                    ui_q  <= lfsr[DATA_W-1:0];
                    uio_q <= lfsr[2*DATA_W-1:DATA_W];
                    lfsr  <= lfsr_step;
                    cnt   <= cnt + CNT_W'(1);
                    misr  <= misr_step;
                end
                S_FLUSH: begin
                    misr <= misr_step;
                    if (last_flush) begin
                        pass_q <= (misr_step == GOLDEN);
                    end else begin
                        fcnt <= fcnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state == S_LOAD) || (state == S_RUN) || (state == S_FLUSH);
    assign done       = (state == S_DONE);
    assign pass       = pass_q;
    assign signature  = misr;
    assign dut_ui     = ui_q;
    assign dut_uio_in = uio_q;

endmodule

// File: tb/tb_tt_selftest_harness.sv
// Bench for tt_selftest_harness: 4-pattern runs against a uo=ui core model, scoreboarded per run.
// Builds with or without HARNESS_UIO_CAPTURE_EN; the reference model follows the same macro.
module tb_tt_selftest_harness;

    localparam int          NPAT    = 4;
    localparam int          LATENCY = 1;
    localparam logic [15:0] GOLDEN  = 16'h0CD4;

    logic       clk = 1'b0;
    logic       rst_n, ena, start;
    logic [7:0] dut_ui, dut_uio_in, dut_uo, dut_uio_out, dut_uio_oe;
    logic       busy, done, pass;
    logic [15:0] signature;
    logic       force_b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // User core stand-in: combinational uo = ui, optionally with bit 0 stuck high.
    assign dut_uo = dut_ui | {7'b0, force_b0};

    tt_selftest_harness #(
        .NPAT    (NPAT),
        .LATENCY (LATENCY),
        .GOLDEN  (GOLDEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .dut_ui      (dut_ui),
        .dut_uio_in  (dut_uio_in),
        .dut_uo      (dut_uo),
        .dut_uio_out (dut_uio_out),
        .dut_uio_oe  (dut_uio_oe),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature)
    );

    typedef struct {
        bit         force_b0;
        logic [7:0] uio_out;
        logic [7:0] uio_oe;
        int         pause_at;
        int         pause_len;
        int         restart_at;
        bit         exp_pass;
    } vec_t;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        logic [7:0]  ui;
        logic [7:0]  uio;
    } exp_t;

    vec_t vecs[7];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic exp_t model(input vec_t v);
        logic [15:0] pat[NPAT];
        logic [15:0] s, m, cap;
        logic [7:0]  ui_val;
        exp_t        e;
        s = 16'hACE1;
        for (int k = 0; k < NPAT; k++) begin
            pat[k] = s;
            s = lfsr_adv(s);
        end
        m = 16'h0;
        for (int i = 0; i < NPAT + LATENCY + 1; i++) begin
            if (i == 0)          ui_val = 8'h00;
            else if (i <= NPAT)  ui_val = pat[i-1][7:0];
            else                 ui_val = pat[NPAT-1][7:0];
            cap = {8'h00, ui_val | {7'b0, v.force_b0}};
`ifdef HARNESS_UIO_CAPTURE_EN
            cap[15:8] = v.uio_out & v.uio_oe;
`endif
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h8005 : 16'h0000) ^ cap;
        end
        e.sig  = m;
        e.pass = v.exp_pass;
        e.ui   = pat[NPAT-1][7:0];
        e.uio  = pat[NPAT-1][15:8];
        return e;
    endfunction

    task automatic do_run(input int id, input vec_t v);
        int          busy_cycles;
        bit          paused, restarted;
        logic [15:0] sig0;
        logic [7:0]  ui0;
        exp_t        e;
        busy_cycles = 0;
        paused      = 0;
        restarted   = 0;
        @(negedge clk);
        force_b0    = v.force_b0;
        dut_uio_out = v.uio_out;
        dut_uio_oe  = v.uio_oe;
        start       = 1'b1;
        exp_q.push_back(model(v));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            start = 1'b0;
            if (done) break;
            if (busy) busy_cycles++;
            if (v.restart_at > 0 && busy_cycles == v.restart_at && !restarted) begin
                restarted = 1;
                start = 1'b1;
            end
            if (v.pause_len > 0 && busy_cycles == v.pause_at && !paused) begin
                paused = 1;
                sig0   = signature;
                ui0    = dut_ui;
                ena    = 1'b0;
                repeat (v.pause_len) @(negedge clk);
                chk($sformatf("v%0d_pause_sig", id), 32'(signature), 32'(sig0));
                chk($sformatf("v%0d_pause_ui", id), 32'(dut_ui), 32'(ui0));
                chk($sformatf("v%0d_pause_busy", id), 32'(busy), 32'(1));
                ena = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("v%0d_done", id), 32'(done), 32'(1));
        chk($sformatf("v%0d_busy_cycles", id), 32'(busy_cycles), 32'(1 + NPAT + LATENCY + 1));
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d_scoreboard_empty", id), 32'(0), 32'(1));
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d_sig", id), 32'(signature), 32'(e.sig));
            chk($sformatf("v%0d_pass", id), 32'(pass), 32'(e.pass));
            chk($sformatf("v%0d_ui", id), 32'(dut_ui), 32'(e.ui));
            chk($sformatf("v%0d_uio", id), 32'(dut_uio_in), 32'(e.uio));
        end
    endtask

    initial begin
        vecs[0] = '{force_b0: 0, uio_out: 8'h00, uio_oe: 8'h00, pause_at: 0, pause_len: 0, restart_at: 0, exp_pass: 1};
        vecs[1] = '{force_b0: 1, uio_out: 8'h00, uio_oe: 8'h00, pause_at: 0, pause_len: 0, restart_at: 0, exp_pass: 0};
        vecs[2] = '{force_b0: 0, uio_out: 8'h00, uio_oe: 8'h00, pause_at: 3, pause_len: 5, restart_at: 0, exp_pass: 1};
        vecs[3] = '{force_b0: 0, uio_out: 8'h00, uio_oe: 8'h00, pause_at: 0, pause_len: 0, restart_at: 2, exp_pass: 1};
`ifdef HARNESS_UIO_CAPTURE_EN
        vecs[4] = '{force_b0: 0, uio_out: 8'hFF, uio_oe: 8'h0F, pause_at: 0, pause_len: 0, restart_at: 0, exp_pass: 0};
`else
        vecs[4] = '{force_b0: 0, uio_out: 8'hFF, uio_oe: 8'h0F, pause_at: 0, pause_len: 0, restart_at: 0, exp_pass: 1};
`endif
        vecs[5] = '{force_b0: 0, uio_out: 8'hFF, uio_oe: 8'h00, pause_at: 0, pause_len: 0, restart_at: 0, exp_pass: 1};
        vecs[6] = '{force_b0: 1, uio_out: 8'h00, uio_oe: 8'h00, pause_at: 4, pause_len: 2, restart_at: 0, exp_pass: 0};

        rst_n       = 1'b0;
        ena         = 1'b1;
        start       = 1'b0;
        force_b0    = 1'b0;
        dut_uio_out = 8'h00;
        dut_uio_oe  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_pass", 32'(pass), 32'(0));
        chk("reset_sig", 32'(signature), 32'(0));
        chk("reset_ui", 32'(dut_ui), 32'(0));
        chk("reset_uio", 32'(dut_uio_in), 32'(0));

        // start while ena is low must be dropped
        ena   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ena   = 1'b1;
        repeat (2) @(negedge clk);
        chk("start_ena_low_busy", 32'(busy), 32'(0));

        for (int i = 0; i < 7; i++) begin
            do_run(i, vecs[i]);
        end

        // reset asserted mid-RUN
        @(negedge clk);
        force_b0    = 1'b0;
        dut_uio_out = 8'h00;
        dut_uio_oe  = 8'h00;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'(1));
        chk("midrun_sig", 32'(signature), 32'(16'h00E1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'(0));
        chk("async_rst_done", 32'(done), 32'(0));
        chk("async_rst_pass", 32'(pass), 32'(0));
        chk("async_rst_sig", 32'(signature), 32'(0));
        chk("async_rst_ui", 32'(dut_ui), 32'(0));
        chk("async_rst_uio", 32'(dut_uio_in), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_run(7, vecs[0]);
        chk("final_sig_golden", 32'(signature), 32'(GOLDEN));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
